hub75_plane_shifter: RTL

//  Parametrised HUB75 column shifter: for one (row, bit-plane) it fetches COLS pixel words

---
 rtl/hub75_plane_shifter_pkg.sv | 23 ++
 rtl/hub75_plane_shifter_counter.sv | 34 +++
 rtl/hub75_plane_shifter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hub75_plane_shifter_pkg.sv
// Shared types and constants for the HUB75 bit-plane column shifter.
package hub75_plane_shifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  localparam int unsigned COLOUR_R = 0;
  localparam int unsigned COLOUR_G = 1;
  localparam int unsigned COLOUR_B = 2;
  localparam int unsigned COLOURS  = 3;

  // Position of (channel, colour) in rgb_out and of its component field in a pixel word.
  function automatic int unsigned rgb_idx(input int unsigned ch, input int unsigned colour);
    return ch * COLOURS + colour;
  endfunction

endpackage

// File: rtl/hub75_plane_shifter_counter.sv
// Up-counter with synchronous clear (priority) and increment enable.
module hub75_plane_shifter_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hub75_plane_shifter.sv
// HUB75 column shifter: fetches COLS pixel words for one (row, bit-plane),
// extracts one BCM bit per colour per channel and clocks them out to the panel.
module hub75_plane_shifter
  import hub75_plane_shifter_pkg::*;
#(
  parameter  int unsigned COLS    = 64,
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned BPC     = 8,
  parameter  int unsigned ROW_W   = 5,
  parameter  int unsigned RD_LAT  = 1,
  parameter  int unsigned CLK_DIV = 1,
  localparam int unsigned COL_W   = $clog2(COLS),
  localparam int unsigned BIT_W   = (BPC > 1) ? $clog2(BPC) : 1,
  localparam int unsigned DW      = NCH * 3 * BPC
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIT_W-1:0]       bit_i,
  input  logic [ROW_W-1:0]       row,
  output logic                   fb_rd_en,
  output logic [ROW_W+COL_W-1:0] fb_addr,
  input  logic [DW-1:0]          fb_rd_data,
  output logic [3*NCH-1:0]       rgb_out,
  output logic                   clk_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned PH_MAX = (RD_LAT > CLK_DIV) ? RD_LAT : CLK_DIV;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned SEL_N  = 1 << BIT_W;

  state_e             state_q;
  logic [BIT_W-1:0]   bit_l_q;
  logic [ROW_W-1:0]   row_l_q;
  logic [3*NCH-1:0]   rgb_q;
  logic [3*NCH-1:0]   plane_bits;
  logic               clk_out_q;
  logic               fb_rd_en_q;
  logic               done_q;
  logic [COL_W-1:0]   col;
  logic [PH_W-1:0]    ph;
  logic               ph_run;
  logic               ph_last;
  logic               ph_clr;
  logic               col_last;
  logic               col_clr;
  logic               col_inc;

  always_comb begin
    ph_last = 1'b0;
    case (state_q)
      ST_WAIT:          ph_last = (ph == PH_W'(RD_LAT - 1));
      ST_LOW, ST_HIGH:  ph_last = (ph == PH_W'(CLK_DIV - 1));
      default:          ph_last = 1'b0;
    endcase
    ph_run   = (state_q == ST_WAIT) || (state_q == ST_LOW) || (state_q == ST_HIGH);
    ph_clr   = !ph_run || ph_last;
    col_last = (col == COL_W'(COLS - 1));
    col_clr  = (state_q == ST_IDLE);
    col_inc  = (state_q == ST_HIGH) && ph_last && !col_last;
  end

  hub75_plane_shifter_counter #(.WIDTH(COL_W)) u_col_cnt (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .clr_i   (col_clr),
    .inc_i   (col_inc),
    .count_o (col)
  );

  hub75_plane_shifter_counter #(.WIDTH(PH_W)) u_phase_cnt (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .clr_i   (ph_clr),
    .inc_i   (ph_run),
    .count_o (ph)
  );

  // Zero-extending each component to 2**BIT_W bits makes out-of-range planes read as 0.
  for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
    for (genvar gk = COLOUR_R; gk <= COLOUR_B; gk++) begin : g_colour
      logic [SEL_N-1:0] comp;
      assign comp = SEL_N'(fb_rd_data[rgb_idx(gc, gk)*BPC +: BPC]);
      assign plane_bits[rgb_idx(gc, gk)] = comp[bit_l_q];
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_l_q    <= '0;
      row_l_q    <= '0;
      rgb_q      <= '0;
      clk_out_q  <= 1'b0;
      fb_rd_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fb_rd_en_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bit_l_q    <= bit_i;
            row_l_q    <= row;
            fb_rd_en_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (ph_last) begin
            rgb_q   <= plane_bits;
            state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (ph_last) begin
            clk_out_q <= 1'b1;
            state_q   <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (ph_last) begin
            clk_out_q <= 1'b0;
            if (col_last) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              fb_rd_en_q <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fb_addr  = {row_l_q, col};
  assign fb_rd_en = fb_rd_en_q;
  assign rgb_out  = rgb_q;
  assign clk_out  = clk_out_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
